// File: rtl/dwt_pkg.sv
// Haar DWT stage shared types, default sizes and helpers.
// Provides the FSM state enum and the scale-shift clamp.
package dwt_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int LEVEL_DEF    = 2;
  localparam int CD_DEPTH_DEF = 256;
  localparam int FRAME_W_DEF  = 9;

  localparam int WIN    = 2 ** LEVEL_DEF;
  localparam int COEF_W = DATA_W_DEF + LEVEL_DEF;
  localparam int PTR_W  = $clog2(CD_DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] clamp_sh(
    input logic [2:0] sh,
    input int         lvl
  );
    logic [2:0] r;
    r = sh;
    if (int'(sh) > lvl) r = 3'(lvl);
    return r;
  endfunction

endpackage

// File: rtl/haar_dwt_stage_ring.sv
// cD history ring: one write port, one registered read port.
// Ports: wr_en/wr_data write newest; rd_addr offset from newest; rd_data, cd_count.
module haar_dwt_stage_ring #(
  parameter int W     = 18,
  parameter int DEPTH = 256,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                wr_en,
  input  logic signed [W-1:0] wr_data,
  input  logic [PW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data,
  output logic [PW:0]         cd_count
);

  logic signed [W-1:0] mem [DEPTH];
  logic [PW-1:0]       wp;
  logic [PW-1:0]       ra;

  // wp points at the next free slot, so newest is wp-1
  assign ra = wp - PW'(1) - rd_addr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wp       <= '0;
      cd_count <= '0;
      rd_data  <= '0;
    end else begin
      rd_data <= mem[ra];
      if (wr_en) begin
        wp <= wp + PW'(1);
        if (cd_count != (PW+1)'(DEPTH))
          cd_count <= cd_count + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/haar_dwt_stage.sv
// Parametrised Haar DWT stage: one cA/cD pair per 2^LEVEL-sample window.
// Ports: start/frame_len/scale_sh/cd_thresh control; in_* and out_* valid/ready streams; rd_* ring read.
module haar_dwt_stage
  import dwt_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEVEL    = LEVEL_DEF,
  parameter int CD_DEPTH = CD_DEPTH_DEF,
  parameter int FRAME_W  = FRAME_W_DEF,
  parameter int CW       = DATA_W + LEVEL,
  parameter int PW       = $clog2(CD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [FRAME_W-1:0]   frame_len,
  input  logic [2:0]           scale_sh,
  input  logic [CW-1:0]        cd_thresh,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] cA,
  output logic signed [CW-1:0] cD,
  output logic                 cd_evt,
  output logic [FRAME_W-1:0]   win_idx,
  output logic                 busy,
  output logic                 done,
  input  logic [PW-1:0]        rd_addr,
  output logic signed [CW-1:0] rd_data,
  output logic [PW:0]          cd_count
);

  state_t state, nxt;

  logic [LEVEL-1:0]     k;
  logic [FRAME_W-1:0]   rem;
  logic [FRAME_W-1:0]   win_cnt;
  logic [2:0]           sh_q;
  logic signed [CW-1:0] s0, s1, x, fs1;
  logic signed [CW-1:0] sa, sd, ca_n, cd_n;
  logic [CW-1:0]        cd_abs;
  logic                 acc, last, hs, go;

  assign x    = {{LEVEL{in_data[DATA_W-1]}}, in_data};
  assign acc  = in_valid && in_ready;
  assign last = acc && (&k);
  assign hs   = out_valid && out_ready;
  assign go   = start && (state != RUN);

  // last sample always falls in the second half, so it joins S1
  assign fs1    = s1 + x;
  assign sa     = s0 + fs1;
  assign sd     = s0 - fs1;
  assign ca_n   = sa >>> sh_q;
  assign cd_n   = sd >>> sh_q;
  assign cd_abs = cd_n[CW-1] ? CW'(-cd_n) : CW'(cd_n);

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (start) nxt = (frame_len == '0) ? DONE : RUN;
      RUN:        if (hs && rem == '0) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  // rem gates intake once every window of the frame has been taken
  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    in_ready = busy && (rem != '0) && !(out_valid && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      k         <= '0;
      rem       <= '0;
      win_cnt   <= '0;
      sh_q      <= '0;
      s0        <= '0;
      s1        <= '0;
      out_valid <= 1'b0;
      cA        <= '0;
      cD        <= '0;
      cd_evt    <= 1'b0;
      win_idx   <= '0;
    end else begin
      if (go) begin
        k       <= '0;
        rem     <= frame_len;
        win_cnt <= '0;
        sh_q    <= clamp_sh(scale_sh, LEVEL);
        s0      <= '0;
        s1      <= '0;
      end else if (acc) begin
        k <= k + LEVEL'(1);
        if (last) begin
          s0      <= '0;
          s1      <= '0;
          rem     <= rem - FRAME_W'(1);
          win_cnt <= win_cnt + FRAME_W'(1);
        end else if (!k[LEVEL-1]) begin
          s0 <= s0 + x;
        end else begin
          s1 <= s1 + x;
        end
      end
      if (last) begin
        out_valid <= 1'b1;
        cA        <= ca_n;
        cD        <= cd_n;
        cd_evt    <= (cd_abs > cd_thresh);
        win_idx   <= win_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  haar_dwt_stage_ring #(
    .W     (CW),
    .DEPTH (CD_DEPTH),
    .PW    (PW)
  ) u_ring (
    .clk      (clk),
    .Reset    (Reset),
    .wr_en    (last),
    .wr_data  (cd_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cd_count (cd_count)
  );

endmodule
